// File: rtl/mem_access_unit_if.sv
// Request, response and bus signals of mem_access_unit grouped as one bundle.
// The slave modport is the unit itself; the master modport is its environment.
interface mem_access_unit_if #(
   parameter int ADDR_W = 64
);
   logic              reqValid;
   logic              reqReady;
   logic [2:0]        reqMode;
   logic              reqStore;
   logic              reqSignExt;
   logic [ADDR_W-1:0] reqAddr;
   logic [63:0]       reqData;

   logic              respValid;
   logic [63:0]       respData;
   logic              respFault;

   logic              busReq;
   logic              busWrite;
   logic [ADDR_W-1:0] busAddr;
   logic [7:0]        busByteEn;
   logic [63:0]       busWData;
   logic [63:0]       busRData;
   logic              busAck;

   modport slave (
      input  reqValid, reqMode, reqStore, reqSignExt, reqAddr, reqData,
      output reqReady,
      output respValid, respData, respFault,
      output busReq, busWrite, busAddr, busByteEn, busWData,
      input  busRData, busAck
   );

   modport master (
      output reqValid, reqMode, reqStore, reqSignExt, reqAddr, reqData,
      input  reqReady,
      input  respValid, respData, respFault,
      input  busReq, busWrite, busAddr, busByteEn, busWData,
      output busRData, busAck
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: issues one or two aligned 64-bit bus beats per request and returns one response.
// Optional: define MEM_ACCESS_ALIGN_TRAP_EN to fault misaligned accesses instead of performing them.
module mem_access_unit #(
   parameter int ADDR_W = 64
) (
   input  logic               clk,
   input  logic               rstN,
   mem_access_unit_if.slave   io
);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        mode_reg;
   logic              store_reg;
   logic              sext_reg;
   logic              fault_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [63:0]       data_reg;
   logic [63:0]       r1_reg;
   logic [63:0]       r2_reg;

   function automatic logic [3:0] mode_bytes(input logic [2:0] mode);
      case (mode)
         3'b001:  return 4'd1;
         3'b010:  return 4'd2;
         3'b011:  return 4'd4;
         3'b100:  return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   logic [3:0] req_n;
   logic       req_fault;
   logic       req_misalign;

   assign req_n = mode_bytes(io.reqMode);
`ifdef MEM_ACCESS_ALIGN_TRAP_EN
   // n is a power of two, so addr mod n is the low bits under mask n-1 (n=8 wraps to 7)
   assign req_misalign = (io.reqAddr[2:0] & 3'(req_n[2:0] - 3'd1)) != 3'd0;
`else
   assign req_misalign = 1'b0;
`endif
   assign req_fault = (req_n == 4'd0) || req_misalign;

   logic [3:0]        n;
   logic [2:0]        off;
   logic              split;
   logic [7:0]        m;
   logic [15:0]       mask16;
   logic [127:0]      wide_w;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [63:0]       raw;
   logic [63:0]       load_result;

   assign n         = mode_bytes(mode_reg);
   assign off       = addr_reg[2:0];
   assign split     = ({1'b0, off} + n) > 4'd8;
   assign m         = (n == 4'd8) ? 8'hFF : 8'((9'd1 << n) - 9'd1);
   // Low halves feed beat 1, high halves beat 2 (equivalent to the right shifts by 8-off)
   assign mask16    = {8'h00, m} << off;
   assign wide_w    = {64'd0, data_reg} << {off, 3'b000};
   assign base_addr = {addr_reg[ADDR_W-1:3], 3'b000};
   assign next_addr = base_addr + ADDR_W'(8);
   assign raw       = 64'({r2_reg, r1_reg} >> {off, 3'b000});

   always_comb begin
      load_result = raw;
      case (mode_reg)
         3'b001:  load_result = {{56{sext_reg & raw[7]}},  raw[7:0]};
         3'b010:  load_result = {{48{sext_reg & raw[15]}}, raw[15:0]};
         3'b011:  load_result = {{32{sext_reg & raw[31]}}, raw[31:0]};
         default: load_result = raw;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg <= IDLE;
         mode_reg  <= 3'd0;
         store_reg <= 1'b0;
         sext_reg  <= 1'b0;
         fault_reg <= 1'b0;
         addr_reg  <= '0;
         data_reg  <= 64'd0;
         r1_reg    <= 64'd0;
         r2_reg    <= 64'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && io.reqValid) begin
            mode_reg  <= io.reqMode;
            store_reg <= io.reqStore;
            sext_reg  <= io.reqSignExt;
            fault_reg <= req_fault;
            addr_reg  <= io.reqAddr;
            data_reg  <= io.reqData;
            r1_reg    <= 64'd0;
            r2_reg    <= 64'd0;
         end
         if (state_reg == BEAT1 && io.busAck) r1_reg <= io.busRData;
         if (state_reg == BEAT2 && io.busAck) r2_reg <= io.busRData;
      end
   end

   always_comb begin
      state_next   = state_reg;
      io.reqReady  = 1'b0;
      io.respValid = 1'b0;
      io.respFault = 1'b0;
      io.respData  = 64'd0;
      io.busReq    = 1'b0;
      io.busWrite  = 1'b0;
      io.busAddr   = '0;
      io.busByteEn = 8'd0;
      io.busWData  = 64'd0;
      case (state_reg)
         IDLE: begin
            io.reqReady = 1'b1;
            if (io.reqValid) state_next = req_fault ? RESP : BEAT1;
         end
         BEAT1: begin
            io.busReq    = 1'b1;
            io.busWrite  = store_reg;
            io.busAddr   = base_addr;
            io.busByteEn = mask16[7:0];
            io.busWData  = wide_w[63:0];
            if (io.busAck) state_next = split ? BEAT2 : RESP;
         end
         BEAT2: begin
            io.busReq    = 1'b1;
            io.busWrite  = store_reg;
            io.busAddr   = next_addr;
            io.busByteEn = mask16[15:8];
            io.busWData  = wide_w[127:64];
            if (io.busAck) state_next = RESP;
         end
         RESP: begin
            io.respValid = 1'b1;
            io.respFault = fault_reg;
            io.respData  = (fault_reg || store_reg) ? 64'd0 : load_result;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed beats and responses, bus acked by the bench.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

`ifdef MEM_ACCESS_ALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   mem_access_unit_if #(.ADDR_W(64)) io ();
   mem_access_unit #(.ADDR_W(64)) dut (.clk(clk), .rstN(rstN), .io(io));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic access(input string tag, input logic [2:0] mode, input logic store,
                         input logic sext, input logic [63:0] addr, input logic [63:0] data,
                         input int wait_cyc, input logic [63:0] rd1, input logic [63:0] rd2,
                         input logic exp_fault, input logic exp_split,
                         input logic [63:0] a1, input logic [7:0] be1, input logic [63:0] w1,
                         input logic [63:0] a2, input logic [7:0] be2, input logic [63:0] w2,
                         input logic [63:0] exp_resp);
      @(negedge clk);
      check({tag, ".ready"}, 64'(io.reqReady), 64'd1);
      io.reqValid = 1'b1; io.reqMode = mode; io.reqStore = store;
      io.reqSignExt = sext; io.reqAddr = addr; io.reqData = data;
      @(negedge clk);
      io.reqValid = 1'b0;
      if (exp_fault) begin
         check({tag, ".f_busreq"}, 64'(io.busReq), 64'd0);
         check({tag, ".f_valid"}, 64'(io.respValid), 64'd1);
         check({tag, ".f_fault"}, 64'(io.respFault), 64'd1);
         check({tag, ".f_data"}, io.respData, 64'd0);
      end else begin
         for (int i = 0; i <= wait_cyc; i++) begin
            check({tag, ".b1_req"}, 64'(io.busReq), 64'd1);
            check({tag, ".b1_wr"}, 64'(io.busWrite), 64'(store));
            check({tag, ".b1_addr"}, io.busAddr, a1);
            check({tag, ".b1_be"}, 64'(io.busByteEn), 64'(be1));
            check({tag, ".b1_wdata"}, io.busWData, w1);
            check({tag, ".b1_resp"}, 64'(io.respValid), 64'd0);
            if (i == wait_cyc) begin io.busAck = 1'b1; io.busRData = rd1; end
            @(negedge clk);
         end
         io.busAck = 1'b0; io.busRData = 64'hDEAD_BEEF_DEAD_BEEF;
         if (exp_split) begin
            check({tag, ".b2_req"}, 64'(io.busReq), 64'd1);
            check({tag, ".b2_addr"}, io.busAddr, a2);
            check({tag, ".b2_be"}, 64'(io.busByteEn), 64'(be2));
            check({tag, ".b2_wdata"}, io.busWData, w2);
            io.busAck = 1'b1; io.busRData = rd2;
            @(negedge clk);
            io.busAck = 1'b0; io.busRData = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         check({tag, ".busreq_off"}, 64'(io.busReq), 64'd0);
         check({tag, ".valid"}, 64'(io.respValid), 64'd1);
         check({tag, ".fault"}, 64'(io.respFault), 64'd0);
         check({tag, ".data"}, io.respData, exp_resp);
      end
      $display("txn %s: addr=%h mode=%b store=%b resp=%h fault=%b", tag, addr, mode, store,
               io.respData, io.respFault);
      @(negedge clk);
      check({tag, ".pulse"}, 64'(io.respValid), 64'd0);
   endtask

   initial begin
      io.reqValid = 1'b0; io.reqMode = 3'd0; io.reqStore = 1'b0; io.reqSignExt = 1'b0;
      io.reqAddr = 64'd0; io.reqData = 64'd0; io.busRData = 64'd0; io.busAck = 1'b0;
      #1;
      check("rst.ready", 64'(io.reqReady), 64'd1);
      check("rst.busreq", 64'(io.busReq), 64'd0);
      check("rst.buswrite", 64'(io.busWrite), 64'd0);
      check("rst.valid", 64'(io.respValid), 64'd0);
      check("rst.fault", 64'(io.respFault), 64'd0);
      check("rst.addr", io.busAddr, 64'd0);
      check("rst.be", 64'(io.busByteEn), 64'd0);
      check("rst.wdata", io.busWData, 64'd0);
      check("rst.rdata", io.respData, 64'd0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;

      access("ld_q", 3'b100, 1'b0, 1'b0, 64'h1000, 64'd0, 0, 64'h8877665544332211, 64'd0,
             1'b0, 1'b0, 64'h1000, 8'hFF, 64'd0, 64'd0, 8'h00, 64'd0, 64'h8877665544332211);
      access("ld_b_sx", 3'b001, 1'b0, 1'b1, 64'h2005, 64'd0, 0, 64'h11229C3344556677, 64'd0,
             1'b0, 1'b0, 64'h2000, 8'h20, 64'd0, 64'd0, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFF9C);
      access("ld_b_zx", 3'b001, 1'b0, 1'b0, 64'h2005, 64'd0, 0, 64'h11229C3344556677, 64'd0,
             1'b0, 1'b0, 64'h2000, 8'h20, 64'd0, 64'd0, 8'h00, 64'd0, 64'h9C);
      access("st_d_split", 3'b011, 1'b1, 1'b0, 64'h3006, 64'hAABBCCDD, 0, 64'h5555, 64'h6666,
             TRAP, 1'b1, 64'h3000, 8'hC0, 64'hCCDD000000000000,
             64'h3008, 8'h03, 64'h000000000000AABB, 64'd0);
      access("ld_w_wrap", 3'b010, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 0,
             64'hAB00000000000000, 64'h00000000000000CD, TRAP, 1'b1,
             64'hFFFFFFFFFFFFFFF8, 8'h80, 64'd0, 64'h0, 8'h01, 64'd0,
             TRAP ? 64'd0 : 64'hFFFFFFFFFFFFCDAB);
      access("ld_d_mis", 3'b011, 1'b0, 1'b1, 64'h1002, 64'd0, 0, 64'h8877665544332211, 64'd0,
             TRAP, 1'b0, 64'h1000, 8'h3C, 64'd0, 64'd0, 8'h00, 64'd0,
             TRAP ? 64'd0 : 64'h66554433);
      access("ld_q_split", 3'b100, 1'b0, 1'b0, 64'h5003, 64'd0, 0, 64'h8877665544332211,
             64'h0000000000CCBBAA, TRAP, 1'b1, 64'h5000, 8'hF8, 64'd0, 64'h5008, 8'h07,
             64'd0, TRAP ? 64'd0 : 64'hCCBBAA8877665544);
      access("st_w_wait", 3'b010, 1'b1, 1'b0, 64'h4002, 64'h1234, 2, 64'hFFFF, 64'd0,
             1'b0, 1'b0, 64'h4000, 8'h0C, 64'h12340000, 64'd0, 8'h00, 64'd0, 64'd0);
      access("st_b_top", 3'b001, 1'b1, 1'b0, 64'h7007, 64'hFF, 0, 64'd0, 64'd0,
             1'b0, 1'b0, 64'h7000, 8'h80, 64'hFF00000000000000, 64'd0, 8'h00, 64'd0, 64'd0);
      access("bad_000", 3'b000, 1'b0, 1'b0, 64'h1000, 64'd0, 0, 64'd0, 64'd0,
             1'b1, 1'b0, 64'd0, 8'h00, 64'd0, 64'd0, 8'h00, 64'd0, 64'd0);
      access("bad_111", 3'b111, 1'b1, 1'b0, 64'h1000, 64'h55, 0, 64'd0, 64'd0,
             1'b1, 1'b0, 64'd0, 8'h00, 64'd0, 64'd0, 8'h00, 64'd0, 64'd0);

      // Reset in the last pending beat with busAck held low
      @(negedge clk);
      io.reqValid = 1'b1; io.reqMode = 3'b011; io.reqStore = 1'b0; io.reqSignExt = 1'b0;
`ifdef MEM_ACCESS_ALIGN_TRAP_EN
      io.reqAddr = 64'h6000;
      @(negedge clk);
      io.reqValid = 1'b0;
      check("rstmid.b1_req", 64'(io.busReq), 64'd1);
`else
      io.reqAddr = 64'h6006;
      @(negedge clk);
      io.reqValid = 1'b0;
      io.busAck = 1'b1; io.busRData = 64'h0123456789ABCDEF;
      @(negedge clk);
      io.busAck = 1'b0;
      check("rstmid.b2_req", 64'(io.busReq), 64'd1);
      check("rstmid.b2_addr", io.busAddr, 64'h6008);
`endif
      #2 rstN = 1'b0;
      #1;
      check("rstmid.busreq", 64'(io.busReq), 64'd0);
      check("rstmid.valid", 64'(io.respValid), 64'd0);
      check("rstmid.ready", 64'(io.reqReady), 64'd1);
      $display("txn rst_mid: reset asserted, busReq=%b", io.busReq);
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rstmid.no_resp", 64'(io.respValid), 64'd0);
      end
      access("ld_q_after", 3'b100, 1'b0, 1'b0, 64'h1000, 64'd0, 0, 64'h8877665544332211, 64'd0,
             1'b0, 1'b0, 64'h1000, 8'hFF, 64'd0, 64'd0, 8'h00, 64'd0, 64'h8877665544332211);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the memory address ALU.
- Takes the computed effective address plus access size, load/store and data.
- Issues aligned 64-bit bus beats with byte enables; splits accesses that cross an 8-byte boundary into two beats.
- Aligns and extends load data, then returns a single response per request.

Parameters:
- ADDR_W, 64: address width; bus addresses are ADDR_W wide with bits [2:0] forced to zero.

Ports:
- clk  in  1  clock, rising edge
- rstN  in  1  asynchronous active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept a request
- reqMode  in  3  size: 001 byte, 010 word, 011 dword, 100 qword (same encoding as the address ALU); any other value is illegal
- reqStore  in  1  1=store, 0=load
- reqSignExt  in  1  loads only: sign-extend (1) or zero-extend (0)
- reqAddr  in  ADDR_W  effective byte address
- reqData  in  64  store data, right-justified
- respValid  out  1  one-cycle response pulse
- respData  out  64  extended load result; 0 for stores and faults
- respFault  out  1  qualifies respValid: illegal mode (or misalignment, see Optional Feature)
- busReq  out  1  bus beat request
- busWrite  out  1  beat is a write
- busAddr  out  ADDR_W  8-byte-aligned beat address
- busByteEn  out  8  active byte lanes, bit i = byte i, little-endian
- busWData  out  64  lane-aligned write data
- busRData  in  64  read data, valid in the busAck cycle
- busAck  in  1  beat completes this cycle

Behaviour:
- Reset values: reqReady=1; respValid=respFault=busReq=busWrite=0; busAddr, busByteEn, busWData and respData all 0. State IDLE.
- Reset is asynchronous. A reset mid-operation drops busReq immediately, discards any partial data and produces no response.
- States:
  - IDLE: reqReady=1. On reqValid, latch all req* fields.
    - Illegal mode -> RESP with fault.
    - Otherwise -> BEAT1.
  - BEAT1: drive beat 1.
    - busAck and split -> BEAT2.
    - busAck and not split -> RESP.
  - BEAT2: drive beat 2. busAck -> RESP.
  - RESP: respValid=1 for exactly one cycle -> IDLE.
- reqReady is 1 only in IDLE.
- busReq is 1 exactly in BEAT1/BEAT2. All bus outputs stay stable until busAck; busAck in other states is ignored.
- Access geometry:
  - n = 1, 2, 4 or 8 bytes.
  - off = addr[2:0].
  - split = (off + n > 8).
  - m = (1<<n) - 1 (8-bit mask, n=8 gives FF).
- Beat 1:
  - busAddr = {addr[ADDR_W-1:3], 000}.
  - busByteEn = (m << off)[7:0].
  - busWData = (data << 8*off)[63:0].
- Beat 2:
  - busAddr = beat-1 address + 8, wrapping modulo 2^ADDR_W.
  - busByteEn = m >> (8 - off).
  - busWData = data >> 8*(8 - off).
- Loads:
  - Capture busRData on each acked beat into r1 (beat 1) and r2 (beat 2; r2 = 0 if not split).
  - raw = ({r2, r1} >> 8*off)[63:0], then masked to n bytes.
  - If reqSignExt, extend from bit 8n-1; otherwise zero-extend.
- Stores: respData = 0; busRData is ignored.
- Latency (ack in first busReq cycle):
  - Request accepted at edge T; busReq high during cycle T+1.
  - Unsplit: respValid during T+2.
  - Split: respValid during T+3.
  - Illegal mode: respValid+respFault during T+1, no bus activity.
- Back-to-back: a new request can be accepted on the edge after the RESP cycle.

Optional Feature:
- Macro MEM_ACCESS_ALIGN_TRAP_EN.
- Defined: any access with addr mod n != 0 is handled like an illegal mode: no bus beat, respFault=1 in RESP, respData=0.
- Not defined: misaligned accesses are performed, splitting across beats when needed, and respFault is only raised for illegal mode.

Test Plan:
- Aligned qword load, addr=0x1000, busRData=0x8877665544332211, ack immediate → busAddr=0x1000, busByteEn=FF; respValid two cycles after accept; respData=0x8877665544332211, respFault=0.
- Byte load signExt=1, addr=0x2005, busRData byte5=0x9C → busByteEn=0x20; respData=0xFFFFFFFFFFFFFF9C. Same with signExt=0 → respData=0x9C.
- Split dword store addr=0x3006, data=0xAABBCCDD:
  - Beat 1: busAddr=0x3000, busByteEn=0xC0, busWData[63:48]=0xCCDD.
  - Beat 2: busAddr=0x3008, busByteEn=0x03, busWData[15:0]=0xAABB.
  - One respValid, respData=0.
- Split word load at addr=0xFFFFFFFFFFFFFFFF → beat-2 busAddr wraps to 0x0; data merged from byte7 of beat 1 and byte0 of beat 2.
- Mode=000 request → no busReq, respValid+respFault next cycle. With MEM_ACCESS_ALIGN_TRAP_EN, dword load at 0x1002 also faults with no bus beat.
- Assert rstN low while in BEAT2 with busAck held low → busReq low immediately, no respValid; after release, reqReady=1 and a new request completes normally.
